// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among 8 requesters, with a dead cycle between grants.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic       dec_en,
  output logic [2:0] dec_sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
    $error("decoder_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_last_idx;
  logic       w_found;
  logic [2:0] w_win;
  logic       w_hold_exp;

  // Rotating priority: search starts just past the last grantee, which is tried last.
  always_comb begin
    logic [2:0] idx;
    w_found = 1'b0;
    w_win   = 3'd0;
    idx     = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = r_last_idx + 3'(k);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  assign w_hold_exp = (r_cnt == CNT_W'(MAX_HOLD));
`else
  assign w_hold_exp = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last_idx <= 3'd7;
      dec_en     <= 1'b0;
      dec_sel    <= 3'd0;
      gnt        <= 8'h00;
      busy       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt      <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_found) begin
            r_state <= S_GRANT;
            dec_en  <= 1'b1;
            dec_sel <= w_win;
            gnt     <= 8'h01 << w_win;
            busy    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= CNT_W'(1);
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          // A drop on the same edge as expiry is an ordinary release, so no timeout pulse.
          if (!req[dec_sel] || w_hold_exp) begin
            r_state    <= S_GAP;
            dec_en     <= 1'b0;
            gnt        <= 8'h00;
            busy       <= 1'b0;
            r_last_idx <= dec_sel;
`ifdef ARB_TIMEOUT_EN
            timeout    <= req[dec_sel];
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
          dec_en  <= 1'b0;
          gnt     <= 8'h00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench for decoder_rr_arbiter: a transaction-level reference model predicts each
// cycle's outputs, a separate monitor compares them after every rising edge.
module tb_decoder_rr_arbiter;

  localparam int TB_MAX_HOLD = 4;
  localparam int TB_CNT_W    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       dec_en;
  logic [2:0] dec_sel;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  decoder_rr_arbiter #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dec_en(dec_en), .dec_sel(dec_sel),
    .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [2:0] sel;
    logic [7:0] g;
    logic       bsy;
    logic       to;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Reference model: who owns the decoder, who owned it last, how long it has been held.
  int m_owner;
  int m_last;
  int m_sel;
  int m_hold;
  bit m_to;

  function automatic int pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (last + k) % 8;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 7; m_sel = 0; m_hold = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner] || (TO_EN && m_hold == TB_MAX_HOLD)) begin
        m_to    = r[m_owner];
        m_last  = m_owner;
        m_owner = -1;
      end else if (m_hold < (1 << TB_CNT_W) - 1) begin
        m_hold++;
      end
    end else begin
      m_owner = pick(r, m_last);
      if (m_owner >= 0) begin
        m_sel  = m_owner;
        m_hold = 1;
      end
    end
  endtask

  task automatic step_now(input logic [7:0] r);
    exp_t e;
    req = r;
    model_step(r);
    e.en  = (m_owner >= 0);
    e.sel = 3'(m_sel);
    e.g   = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    e.bsy = (m_owner >= 0);
    e.to  = m_to;
    q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r);
    @(negedge clk);
    step_now(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (dec_en !== 1'b0 || gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0 || dec_sel !== 3'd0) begin
      n_err++;
      $display("FAIL %s: got en=%b sel=%0d gnt=%h busy=%b to=%b, want all zero", tag,
               dec_en, dec_sel, gnt, busy, timeout);
    end
  endtask

  // Assert reset between edges, check it acts at once, release with r sampled on the next edge.
  task automatic do_reset(input logic [7:0] r_hold, input logic [7:0] r_rel, input string tag);
    @(negedge clk);
    #2;
    req   = r_hold;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    check_reset_outputs({tag, "_held"});
    model_reset();
    rst_n = 1'b1;
    step_now(r_rel);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (dec_en !== e.en || dec_sel !== e.sel || gnt !== e.g || busy !== e.bsy || timeout !== e.to) begin
          n_err++;
          $display("FAIL cycle@%0t: got en=%b sel=%0d gnt=%h busy=%b to=%b, want en=%b sel=%0d gnt=%h busy=%b to=%b",
                   $time, dec_en, dec_sel, gnt, busy, timeout, e.en, e.sel, e.g, e.bsy, e.to);
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] r;
    model_reset();

    // Reset with every request up, then first grant goes to requester 0.
    do_reset(8'hFF, 8'hFF, "reset_ff");
    repeat (3) step(8'hFF);

    // Round robin over 0,2,7: each grantee drops after two grant cycles.
    do_reset(8'h00, 8'h85, "reset_rr");
    for (int c = 0; c < 16; c++) begin
      r = 8'h85;
      if (m_owner >= 0 && m_hold >= 2) r[m_owner] = 1'b0;
      step(r);
    end

    // Wrap-around from requester 6 back to 0, then 6.
    do_reset(8'h00, 8'h40, "reset_wrap");
    step(8'h40);
    step(8'h00);
    step(8'h41);
    step(8'h41);
    step(8'h40);
    step(8'h41);
    step(8'h41);
    step(8'h00);

    // Long hold on requester 3 (forced release only when the timeout build is used).
    do_reset(8'h00, 8'h08, "reset_hold");
    repeat (50) step(8'h08);

    // Two requesters held constantly: alternation under timeout, indefinite hold otherwise.
    do_reset(8'h00, 8'h18, "reset_to");
    repeat (20) step(8'h18);

    // Drop on the same edge a timeout would fire.
    do_reset(8'h00, 8'h02, "reset_tie");
    repeat (TB_MAX_HOLD - 1) step(8'h02);
    step(8'h00);
    step(8'h00);

    // Reset mid-grant of requester 5, then restart from 0.
    do_reset(8'h00, 8'h20, "reset_pre");
    repeat (3) step(8'h20);
    do_reset(8'h20, 8'h21, "reset_mid");
    repeat (4) step(8'h21);

    // Randomised traffic with occasional resets.
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(8'($urandom), 8'($urandom), "reset_rand");
        r = req;
      end else begin
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
        if ($urandom_range(0, 40) == 0) r = 8'h00;
        step(r);
      end
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
